// File: rtl/aes_inv_cipher_core_pkg.sv
// aes_inv_cipher_core_pkg: shared AES constants, FSM encoding and GF(2^8) helpers.
// Contents: AES_NR, BLOCK_W, RK_IDX_W, fsm_state_t, gf_mul(), inv_sbox().
package aes_inv_cipher_core_pkg;
    localparam int AES_NR   = 10;
    localparam int BLOCK_W  = 128;
    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_state_t;

    // One InvMixColumns matrix row; row r is this row rotated right by r bytes.
    localparam logic [31:0] INV_MIX = 32'h0e0b0d09;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1; constant b folds away.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction
endpackage

// File: rtl/aes_inv_cipher_core_round.sv
// aes_inv_round: one combinational AES inverse round.
// Ports: state (current block), rk (round key), last (skip InvMixColumns), result (next block).
// Byte i of a block sits at bits [127-8i -: 8] and maps to row i%4, column i/4.
module aes_inv_round
    import aes_inv_cipher_core_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] rk,
    input  logic               last,
    output logic [BLOCK_W-1:0] result
);
    logic [BLOCK_W-1:0] shifted, subbed, keyed, mixed;

    // InvShiftRows: row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r+4)%4)+r) -: 8];
    end

    aes_inv_subbytes u_sub (
        .data   (shifted),
        .result (subbed)
    );

    assign keyed = subbed ^ rk;

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    mixed[127-8*(4*c+r) -: 8] ^= gf_mul(keyed[127-8*(4*c+k) -: 8],
                                                        INV_MIX[31-8*((k-r+4)%4) -: 8]);
    end

    assign result = last ? keyed : mixed;
endmodule

// File: rtl/aes_inv_subbytes.sv
// aes_inv_subbytes: applies the AES inverse S-box to all 16 bytes of a block.
// Ports: data (block in), result (substituted block out). Purely combinational.
module aes_inv_subbytes
    import aes_inv_cipher_core_pkg::*;
(
    input  logic [BLOCK_W-1:0] data,
    output logic [BLOCK_W-1:0] result
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign result[BLOCK_W-1-8*i -: 8] = inv_sbox(data[BLOCK_W-1-8*i -: 8]);
    end
endmodule

// File: rtl/aes_inv_cipher_core.sv
// aes_inv_cipher_core: iterative AES-128 decryptor, one inverse round per clock.
// Ports: clk, rst (async, active-high); in_valid/in_ready/ciphertext input handshake;
// rk_idx/rk external round-key lookup (combinational); out_valid/out_ready/plaintext
// output handshake; busy high outside IDLE.
module aes_inv_cipher_core
    import aes_inv_cipher_core_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  ciphertext,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [BLOCK_W-1:0]  rk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  plaintext,
    output logic                busy
);
    fsm_state_t          st;
    logic [RK_IDX_W-1:0] r;
    logic [BLOCK_W-1:0]  data, round_out;

    aes_inv_round u_round (
        .state  (data),
        .rk     (rk),
        .last   (r == '0),
        .result (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            r    <= '0;
            data <= '0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    data <= ciphertext ^ rk;
                    r    <= RK_IDX_W'(NR - 1);
                    st   <= ROUND;
                end
                ROUND: begin
                    data <= round_out;
                    r    <= r - RK_IDX_W'(1);
                    if (r == '0) st <= DONE;
                end
                DONE: if (out_ready) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

    // The initial whitening key is NR, so IDLE and DONE present NR to the key store.
    assign rk_idx    = (st == ROUND) ? r : RK_IDX_W'(NR);
    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign busy      = (st != IDLE);
    assign plaintext = data;
endmodule
